// File: rtl/traffic_pkg.sv
// Shared colour encodings, tracker states, fault codes and light indices for the
// T-intersection light monitor.
package traffic_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RED,
    ST_GRN,
    ST_YEL
  } trk_state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ENC       = 3'd1;
  localparam logic [2:0] FC_TRANS     = 3'd2;
  localparam logic [2:0] FC_CONFLICT  = 3'd3;
  localparam logic [2:0] FC_YEL_SHORT = 3'd4;
  localparam logic [2:0] FC_YEL_LONG  = 3'd5;
  localparam logic [2:0] FC_GRN_LONG  = 3'd6;

  localparam logic [1:0] LI_M1 = 2'd0;
  localparam logic [1:0] LI_M2 = 2'd1;
  localparam logic [1:0] LI_MT = 2'd2;
  localparam logic [1:0] LI_S  = 2'd3;

  // A lamp showing GREEN or YELLOW still lets traffic into the junction.
  function automatic logic is_active(input logic [2:0] colour);
    return (colour == GRN) || (colour == YEL);
  endfunction

  function automatic logic [1:0] first_idx(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/light_track.sv
// Per-lamp colour-sequence tracker with saturating dwell counter; raises one-cycle
// violation flags for the sample currently on light_i.
module light_track
  import traffic_pkg::*;
#(
  parameter int YEL_MIN   = 2,
  parameter int YEL_MAX   = 3,
  parameter int GREEN_MAX = 7,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_i,
  output logic       bad_enc_o,
  output logic       bad_trans_o,
  output logic       yel_short_o,
  output logic       yel_long_o,
  output logic       grn_long_o
);

  localparam logic [CNT_W-1:0] DWELL_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_SAT   = '1;
  localparam logic [CNT_W-1:0] YEL_MIN_C   = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] YEL_MAX_C   = CNT_W'(YEL_MAX);
  localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);

  trk_state_e       state_q, state_d, colour;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             legal;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    legal  = 1'b1;
    colour = ST_INIT;
    case (light_i)
      RED:     colour = ST_RED;
      YEL:     colour = ST_YEL;
      GRN:     colour = ST_GRN;
      default: legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    bad_trans_o = 1'b0;
    yel_short_o = 1'b0;
    yel_long_o  = 1'b0;
    grn_long_o  = 1'b0;
    // An illegal encoding freezes both state and dwell until a legal colour returns.
    if (legal) begin
      state_d = colour;
      if (state_q == ST_INIT) begin
        dwell_d = DWELL_ONE;
      end else if (colour == state_q) begin
        if (dwell_q != DWELL_SAT) dwell_d = dwell_q + 1'b1;
        yel_long_o = (state_q == ST_YEL) && (dwell_q == YEL_MAX_C);
        grn_long_o = (state_q == ST_GRN) && (dwell_q == GREEN_MAX_C);
      end else begin
        dwell_d     = DWELL_ONE;
        bad_trans_o = !((state_q == ST_RED && colour == ST_GRN) ||
                        (state_q == ST_GRN && colour == ST_YEL) ||
                        (state_q == ST_YEL && colour == ST_RED));
        yel_short_o = (state_q == ST_YEL) && (dwell_q < YEL_MIN_C);
      end
    end
  end

  assign bad_enc_o = !legal;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= ST_INIT;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker beside the intersection controller: four lamp trackers, conflict
// detection, lowest-code priority, sticky first-fault capture, all-red and S-phase count.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int YEL_MIN   = 2,
  parameter int YEL_MAX   = 3,
  parameter int GREEN_MAX = 7,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_light,
  output logic       all_red,
  output logic [7:0] cycle_cnt
);

  logic [3:0][2:0] lamp;
  logic [3:0]      enc_v, trans_v, conf_v, ys_v, yl_v, gl_v;
  logic [2:0]      viol_code, pend_code_q, fault_code_q;
  logic [1:0]      viol_light, pend_light_q, fault_light_q;
  logic            fault_q, all_red_q, s_grn_q;
  logic [7:0]      cycle_cnt_q;

  assign lamp[LI_M1] = light_M1;
  assign lamp[LI_M2] = light_M2;
  assign lamp[LI_MT] = light_MT;
  assign lamp[LI_S]  = light_S;

  for (genvar i = 0; i < 4; i++) begin : g_trk
    light_track #(
      .YEL_MIN  (YEL_MIN),
      .YEL_MAX  (YEL_MAX),
      .GREEN_MAX(GREEN_MAX),
      .CNT_W    (CNT_W)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .light_i    (lamp[i]),
      .bad_enc_o  (enc_v[i]),
      .bad_trans_o(trans_v[i]),
      .yel_short_o(ys_v[i]),
      .yel_long_o (yl_v[i]),
      .grn_long_o (gl_v[i])
    );
  end

  // Conflicts are blamed on S when it is involved, otherwise on the turn lamp.
  always_comb begin
    conf_v = '0;
    if (is_active(light_S) &&
        (is_active(light_M1) || is_active(light_M2) || is_active(light_MT)))
      conf_v[LI_S] = 1'b1;
    else if (is_active(light_MT) && is_active(light_M1))
      conf_v[LI_MT] = 1'b1;
  end

  always_comb begin
    viol_code  = FC_NONE;
    viol_light = LI_M1;
    if (|enc_v) begin
      viol_code = FC_ENC;       viol_light = first_idx(enc_v);
    end else if (|trans_v) begin
      viol_code = FC_TRANS;     viol_light = first_idx(trans_v);
    end else if (|conf_v) begin
      viol_code = FC_CONFLICT;  viol_light = first_idx(conf_v);
    end else if (|ys_v) begin
      viol_code = FC_YEL_SHORT; viol_light = first_idx(ys_v);
    end else if (|yl_v) begin
      viol_code = FC_YEL_LONG;  viol_light = first_idx(yl_v);
    end else if (|gl_v) begin
      viol_code = FC_GRN_LONG;  viol_light = first_idx(gl_v);
    end
  end

  // Violations are staged one cycle before the sticky capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_code_q   <= FC_NONE;
      pend_light_q  <= LI_M1;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      fault_light_q <= LI_M1;
      all_red_q     <= 1'b0;
      s_grn_q       <= 1'b0;
      cycle_cnt_q   <= '0;
    end else begin
      pend_code_q  <= viol_code;
      pend_light_q <= viol_light;
      if (!fault_q && pend_code_q != FC_NONE) begin
        fault_q       <= 1'b1;
        fault_code_q  <= pend_code_q;
        fault_light_q <= pend_light_q;
      end
      all_red_q <= (light_M1 == RED) && (light_M2 == RED) &&
                   (light_MT == RED) && (light_S == RED);
      if (light_S == GRN)                           s_grn_q <= 1'b1;
      else if (light_S == RED || light_S == YEL)    s_grn_q <= 1'b0;
      if (s_grn_q && light_S == YEL) cycle_cnt_q <= cycle_cnt_q + 8'd1;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign fault_light = fault_light_q;
  assign all_red     = all_red_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios with literal expectations plus
// randomized lamp sequences compared every cycle against a run-length reference model.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int YEL_MIN   = 2;
  localparam int YEL_MAX   = 3;
  localparam int GREEN_MAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] m1 = RED, m2 = RED, mt = RED, s = RED;
  logic       fault, all_red;
  logic [2:0] fault_code;
  logic [1:0] fault_light;
  logic [7:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit fresh = 1'b1;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GREEN_MAX(GREEN_MAX), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .light_M1(m1), .light_M2(m2), .light_MT(mt), .light_S(s),
    .fault(fault), .fault_code(fault_code), .fault_light(fault_light),
    .all_red(all_red), .cycle_cnt(cycle_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per lamp: last legal colour seen (0 = nothing yet) and how many consecutive
  // samples it has shown that colour.
  logic [2:0] last_col [4];
  int         run_len  [4];
  logic       m_fault, m_all_red;
  logic [2:0] m_code, m_pcode;
  logic [1:0] m_light, m_plight;
  logic [7:0] m_cnt;
  int         best_c, best_l;

  function automatic logic [2:0] legal_next(input logic [2:0] c);
    if (c == RED) return GRN;
    if (c == GRN) return YEL;
    return RED;
  endfunction

  function automatic bit act(input logic [2:0] c);
    return (c == GRN) || (c == YEL);
  endfunction

  task automatic note(input int code, input int li);
    if (code < best_c || (code == best_c && li < best_l)) begin
      best_c = code;
      best_l = li;
    end
  endtask

  always @(posedge clk) begin : model
    logic [2:0] lmp [4];
    logic [2:0] c;
    int inc;
    lmp[0] = m1; lmp[1] = m2; lmp[2] = mt; lmp[3] = s;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin last_col[i] = 3'd0; run_len[i] = 0; end
      m_fault = 0; m_code = 0; m_light = 0; m_pcode = 0; m_plight = 0;
      m_all_red = 0; m_cnt = 0;
    end else begin
      best_c = 7; best_l = 0; inc = 0;
      for (int i = 0; i < 4; i++) begin
        c = lmp[i];
        if (!(c == RED || c == YEL || c == GRN)) note(1, i);
        else if (last_col[i] == 3'd0) begin
          last_col[i] = c; run_len[i] = 1;
        end else if (c == last_col[i]) begin
          run_len[i]++;
          if (c == YEL && run_len[i] == YEL_MAX + 1)   note(5, i);
          if (c == GRN && run_len[i] == GREEN_MAX + 1) note(6, i);
        end else begin
          if (c != legal_next(last_col[i]))              note(2, i);
          if (last_col[i] == YEL && run_len[i] < YEL_MIN) note(4, i);
          if (i == 3 && last_col[i] == GRN && c == YEL)   inc = 1;
          last_col[i] = c; run_len[i] = 1;
        end
      end
      if (act(s) && (act(m1) || act(m2) || act(mt))) note(3, 3);
      else if (act(mt) && act(m1))                    note(3, 2);
      if (!m_fault && m_pcode != 0) begin
        m_fault = 1; m_code = m_pcode; m_light = m_plight;
      end
      m_pcode   = (best_c == 7) ? 3'd0 : 3'(best_c);
      m_plight  = 2'(best_l);
      m_all_red = (m1 == RED) && (m2 == RED) && (mt == RED) && (s == RED);
      m_cnt     = m_cnt + 8'(inc);
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("outputs{fault,code,light,all_red,cnt}",
            32'({fault, fault_code, fault_light, all_red, cycle_cnt}),
            32'({m_fault, m_code, m_light, m_all_red, m_cnt}));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] d);
    m1 = a; m2 = b; mt = c; s = d;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(RED, RED, RED, RED);
    drive(RED, RED, RED, RED);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic expect_fault(input string name, input logic f,
                              input logic [2:0] code, input logic [1:0] li);
    check({name, "_fault"}, 32'(fault), 32'(f));
    check({name, "_code"},  32'(fault_code), 32'(code));
    check({name, "_light"}, 32'(fault_light), 32'(li));
  endtask

  function automatic logic [2:0] pick_legal();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? RED : (r == 1) ? YEL : GRN;
  endfunction

  function automatic logic [2:0] rnd_next(input logic [2:0] cur, input bit first);
    int r;
    if (first) return pick_legal();
    r = $urandom_range(0, 99);
    if (r < 55) return cur;
    if (r < 85) return (cur == RED || cur == YEL || cur == GRN) ? legal_next(cur) : RED;
    if (r < 97) return pick_legal();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    // Legal M and S phases: no fault, one completed S green phase.
    do_reset;
    expect_fault("reset", 1'b0, 3'd0, 2'd0);
    check("reset_all_red", 32'(all_red), 32'd0);
    check("reset_cnt", 32'(cycle_cnt), 32'd0);
    drive(RED, RED, RED, RED);
    repeat (5) drive(GRN, GRN, RED, RED);
    repeat (3) drive(YEL, YEL, RED, RED);
    drive(RED, RED, RED, RED);
    repeat (5) drive(RED, RED, RED, GRN);
    repeat (2) drive(RED, RED, RED, YEL);
    drive(RED, RED, RED, RED);
    drive(RED, RED, RED, RED);
    expect_fault("legal", 1'b0, 3'd0, 2'd0);
    check("legal_cnt", 32'(cycle_cnt), 32'd1);
    check("legal_all_red", 32'(all_red), 32'd1);

    // S green together with M1 green.
    do_reset;
    drive(RED, RED, RED, RED);
    drive(GRN, RED, RED, GRN);
    check("conflict_latency", 32'(fault), 32'd0);
    drive(GRN, RED, RED, RED);
    expect_fault("conflict", 1'b1, 3'd3, 2'd3);

    // M2 green straight to red.
    do_reset;
    drive(RED, RED, RED, RED);
    repeat (2) drive(RED, GRN, RED, RED);
    drive(RED, RED, RED, RED);
    drive(RED, RED, RED, RED);
    expect_fault("m2_g2r", 1'b1, 3'd2, 2'd1);

    // MT yellow held four cycles.
    do_reset;
    drive(RED, RED, RED, RED);
    drive(RED, RED, GRN, RED);
    repeat (4) drive(RED, RED, YEL, RED);
    check("yel_long_latency", 32'(fault), 32'd0);
    drive(RED, RED, RED, RED);
    expect_fault("yel_long", 1'b1, 3'd5, 2'd2);

    // MT yellow for a single cycle.
    do_reset;
    drive(RED, RED, RED, RED);
    drive(RED, RED, GRN, RED);
    drive(RED, RED, YEL, RED);
    drive(RED, RED, RED, RED);
    drive(RED, RED, RED, RED);
    expect_fault("yel_short", 1'b1, 3'd4, 2'd2);

    // Illegal S encoding beats M1 yellow-short; later faults do not overwrite it.
    do_reset;
    drive(RED, RED, RED, RED);
    drive(GRN, RED, RED, RED);
    drive(YEL, RED, RED, RED);
    drive(RED, RED, RED, 3'b111);
    drive(RED, RED, RED, RED);
    expect_fault("enc_prio", 1'b1, 3'd1, 2'd3);
    drive(GRN, RED, RED, GRN);
    drive(GRN, RED, RED, GRN);
    drive(RED, RED, RED, RED);
    expect_fault("sticky", 1'b1, 3'd1, 2'd3);

    // Reset in the middle of a long green restarts the dwell count.
    do_reset;
    drive(RED, RED, RED, RED);
    repeat (6) drive(GRN, RED, RED, RED);
    rst = 1'b1;
    drive(GRN, RED, RED, RED);
    rst = 1'b0;
    repeat (7) drive(GRN, RED, RED, RED);
    drive(YEL, RED, RED, RED);
    expect_fault("mid_rst", 1'b0, 3'd0, 2'd0);
    check("mid_rst_all_red", 32'(all_red), 32'd0);

    // Randomized segments; odd segments keep MT and S red so timing faults surface.
    for (int seg = 0; seg < 40; seg++) begin
      do_reset;
      fresh = 1'b1;
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 99) < 3) begin
          rst = 1'b1;
          drive(m1, m2, mt, s);
          rst = 1'b0;
          fresh = 1'b1;
        end
        if (seg % 2 == 1)
          drive(rnd_next(m1, fresh), rnd_next(m2, fresh), RED, RED);
        else
          drive(rnd_next(m1, fresh), rnd_next(m2, fresh),
                rnd_next(mt, fresh), rnd_next(s, fresh));
        fresh = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
